// File: rtl/uart_rx_ext.sv
// Runtime-configurable UART receiver: 5..MAX_DATA_BITS data, none/even/odd parity, 1/2 stop bits.
// Output registered 1 cycle after the completing mid tick; a character arriving while one is held is dropped with overrun.
module uart_rx_ext #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     rx,
  input  logic                     cfg_en,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     break_det,
  output logic                     overrun,
  output logic                     busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] S_V0   = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] S_V1   = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] S_MID  = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] S_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     rxs_prev_q;
  logic [CW-1:0]            s_cnt_q, s_cnt_d;
  logic                     v0_q, v0_d, v1_q, v1_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     par_bit_q, par_bit_d, fe_q, fe_d;
  logic [MAX_DATA_BITS-1:0] dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic                     frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                     break_det_q, break_det_d, overrun_q, overrun_d;

  logic       rxs, mid_tick, voted, cmpl, c_fe, c_pe, c_brk, load;
  logic [3:0] cfg_nbits;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign mid_tick = tick && (s_cnt_q == S_MID);
  assign voted    = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
  assign cfg_nbits = (cfg_data_bits < 4'd5) ? 4'd5 :
                     (cfg_data_bits > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) : cfg_data_bits;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    fe_d       = fe_q;
    cmpl       = 1'b0;
    c_fe       = 1'b0;
    c_pe       = 1'b0;
    c_brk      = 1'b0;

    if (tick) begin
      s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
      if (s_cnt_q == S_V0) v0_d = rxs;
      if (s_cnt_q == S_V1) v1_d = rxs;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_en && rxs_prev_q && !rxs) begin
          state_d   = S_START;
          s_cnt_d   = '0;
          nbits_d   = cfg_nbits;
          par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          par_odd_d = (cfg_parity == 2'b10);
          stop2_d   = cfg_stop2;
          bit_cnt_d = '0;
          shreg_d   = '0;
          par_bit_d = 1'b0;
          fe_d      = 1'b0;
        end
      end
      S_START: begin
        if (mid_tick) state_d = voted ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid_tick) begin
          shreg_d[bit_cnt_q] = voted;
          if (bit_cnt_q == 4'(nbits_q - 4'd1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (mid_tick) begin
          par_bit_d = voted;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (mid_tick) begin
          // par_bit_q is 0 when parity is off, so it never blocks break detection
          if (!voted && bit_cnt_q == 4'd0 && shreg_q == '0 && !par_bit_q) begin
            cmpl    = 1'b1;
            c_brk   = 1'b1;
            c_fe    = 1'b1;
            state_d = S_BRK_WAIT;
          end else if (stop2_q && bit_cnt_q == 4'd0) begin
            fe_d      = fe_q | !voted;
            bit_cnt_d = 4'd1;
          end else begin
            cmpl    = 1'b1;
            c_fe    = fe_q | !voted;
            c_pe    = par_en_q & (^shreg_q ^ par_bit_q ^ par_odd_q);
            state_d = S_IDLE;
          end
        end
      end
      S_BRK_WAIT: begin
        if (tick && rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    load         = cmpl && (!dout_valid_q || dout_ready);
    overrun_d    = cmpl && !load;
    dout_d       = dout_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    break_det_d  = break_det_q;
    dout_valid_d = dout_valid_q;
    if (load) begin
      dout_d       = shreg_q;
      frame_err_d  = c_fe;
      parity_err_d = c_pe;
      break_det_d  = c_brk;
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      rxs_prev_q   <= 1'b1;
      s_cnt_q      <= '0;
      v0_q         <= 1'b1;
      v1_q         <= 1'b1;
      bit_cnt_q    <= '0;
      nbits_q      <= 4'd5;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      fe_q         <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      rxs_prev_q   <= rxs;
      s_cnt_q      <= s_cnt_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      bit_cnt_q    <= bit_cnt_d;
      nbits_q      <= nbits_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      stop2_q      <= stop2_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      fe_q         <= fe_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: frames built from bit lists, expected characters derived from the framing rules.
module tb_uart_rx_ext;

  logic       clk, rst, tick, rx, cfg_en, cfg_stop2, dout_valid, dout_ready;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic [8:0] dout;
  logic       frame_err, parity_err, break_det, overrun, busy;

  uart_rx_ext #(.MAX_DATA_BITS(9), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx), .cfg_en(cfg_en),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det),
    .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [8:0] dat; logic fe; logic pe; logic brk; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_err = 0;
  int vcount = 0, ovr_cnt = 0, tcnt = 0, rdy_mode = 1;
  logic prev_valid = 1'b0, prev_hs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: observe outputs after the last edge, then drive inputs for the next edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (dout_valid) vcount++;
    if (overrun) ovr_cnt++;
    if (!rst && dout_valid && (!prev_valid || prev_hs)) begin
      chk("char_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout", dout, e.dat);
        chk("frame_err", frame_err, e.fe);
        chk("parity_err", parity_err, e.pe);
        chk("break_det", break_det, e.brk);
      end
    end
    tcnt = (tcnt + 1) % 2;
    tick = (tcnt == 0);
    dout_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    prev_valid = dout_valid;
    prev_hs    = dout_valid && dout_ready;
  endtask

  task automatic hold(input logic b, input int nt);
    int c;
    rx = b;
    c = 0;
    while (c < nt) begin
      step();
      if (tick) c++;
    end
  endtask

  // chg_at: data-bit index at which cfg is scrambled (and cfg_en dropped) mid-frame
  task automatic send_frame(input logic [3:0] nbc, input logic [1:0] par, input logic st2,
                            input logic [8:0] data, input logic pflip, input logic s1,
                            input logic s2, input int gap, input logic expect_out,
                            input int chg_at);
    int nb;
    logic pen, podd, pbit;
    logic [8:0] d;
    exp_t e;
    nb   = (nbc < 5) ? 5 : (nbc > 9) ? 9 : int'(nbc);
    pen  = (par == 2'b01) || (par == 2'b10);
    podd = (par == 2'b10);
    d    = data & 9'((1 << nb) - 1);
    pbit = (^d) ^ podd ^ pflip;
    cfg_data_bits = nbc; cfg_parity = par; cfg_stop2 = st2;
    e.brk = (d == 0) && (!pen || !pbit) && !s1;
    e.dat = e.brk ? 9'd0 : d;
    e.fe  = e.brk ? 1'b1 : (!s1 || (st2 && !s2));
    e.pe  = e.brk ? 1'b0 : (pen && (((^d) ^ pbit) != podd));
    if (expect_out) exp_q.push_back(e);
    hold(1'b0, 16);
    for (int i = 0; i < nb; i++) begin
      if (i == chg_at) begin
        cfg_data_bits = 4'd5; cfg_parity = 2'b10; cfg_stop2 = ~st2; cfg_en = 1'b0;
      end
      hold(d[i], 16);
    end
    if (pen) hold(pbit, 16);
    hold(s1, 16);
    if (st2) hold(s2, 16);
    if (gap > 0) hold(1'b1, gap);
  endtask

  initial begin
    int v0, o0, gap, nbc;
    logic [1:0] par;
    logic st2, s1, s2, pf;
    logic [8:0] data;

    rst = 1'b1; tick = 1'b0; rx = 1'b1; cfg_en = 1'b1; dout_ready = 1'b1;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (3) step();
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_flags", {frame_err, parity_err, break_det}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    hold(1'b1, 32);

    // 8N1 0xA5, valid for exactly one cycle with ready held high
    v0 = vcount;
    send_frame(4'd8, 2'b00, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 32, 1'b1, -1);
    chk("a5_valid_cycles", vcount - v0, 1);
    chk("a5_busy_idle", busy, 0);

    // 7E2 with flipped parity, then 7E1 with a bad stop bit
    send_frame(4'd7, 2'b01, 1'b1, 9'h041, 1'b1, 1'b1, 1'b1, 16, 1'b1, -1);
    send_frame(4'd7, 2'b01, 1'b0, 9'h041, 1'b0, 1'b0, 1'b1, 32, 1'b1, -1);

    // 6-tick glitch: busy briefly, no character
    v0 = vcount;
    hold(1'b0, 6);
    hold(1'b1, 2);
    chk("glitch_busy_start", busy, 1);
    hold(1'b1, 8);
    chk("glitch_busy_clear", busy, 0);
    chk("glitch_no_char", vcount - v0, 0);

    // Break: two frame times low, then release
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    exp_q.push_back('{dat: 9'd0, fe: 1'b1, pe: 1'b0, brk: 1'b1});
    hold(1'b0, 16 * 20);
    chk("break_wait_busy", busy, 1);
    hold(1'b1, 8);
    chk("break_idle", busy, 0);
    hold(1'b1, 24);

    // Backpressure: second character is dropped with one overrun pulse
    rdy_mode = 0;
    o0 = ovr_cnt;
    send_frame(4'd8, 2'b00, 1'b0, 9'h011, 1'b0, 1'b1, 1'b1, 0, 1'b1, -1);
    send_frame(4'd8, 2'b00, 1'b0, 9'h022, 1'b0, 1'b1, 1'b1, 32, 1'b0, -1);
    chk("bp_overrun_pulses", ovr_cnt - o0, 1);
    chk("bp_dout_held", dout, 9'h011);
    chk("bp_valid_held", dout_valid, 1);
    rdy_mode = 1;
    hold(1'b1, 4);
    chk("bp_drained", dout_valid, 0);

    // Reset mid-DATA with a character held, then a clean frame with mid-frame cfg changes
    rdy_mode = 0;
    send_frame(4'd8, 2'b00, 1'b0, 9'h05A, 1'b0, 1'b1, 1'b1, 8, 1'b1, -1);
    hold(1'b0, 16); hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 8);
    chk("pre_rst_busy", busy, 1);
    rx = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {frame_err, parity_err, break_det, overrun}, 0);
    rdy_mode = 1;
    hold(1'b1, 32);
    send_frame(4'd8, 2'b00, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, 32, 1'b1, 2);
    chk("cfg_en_frame_done", busy, 0);
    send_frame(4'd8, 2'b00, 1'b0, 9'h0C3, 1'b0, 1'b1, 1'b1, 32, 1'b0, -1);
    cfg_en = 1'b1;
    hold(1'b1, 16);

    // Randomised frames with random backpressure
    rdy_mode = 2;
    o0 = ovr_cnt;
    for (int k = 0; k < 40; k++) begin
      nbc  = $urandom_range(0, 15);
      par  = 2'($urandom_range(0, 3));
      st2  = 1'($urandom_range(0, 1));
      data = 9'($urandom_range(0, 511));
      pf   = ($urandom_range(0, 7) == 0);
      s1   = ($urandom_range(0, 7) != 0);
      s2   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin data = 9'd0; s1 = 1'b0; end
      gap = ((st2 ? s2 : s1) == 1'b0) ? 32 : $urandom_range(0, 3);
      send_frame(4'(nbc), par, st2, data, pf, s1, s2, gap, 1'b1, -1);
    end
    rdy_mode = 1;
    hold(1'b1, 64);
    chk("rand_no_overrun", ovr_cnt - o0, 0);
    chk("all_chars_seen", exp_q.size(), 0);
    chk("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
